// File: rtl/sparse_vector_loader.sv
// Sparse (index, value) beat collector feeding a dense 16 x 8-bit vector slot.
// Optional macro LOADER_ZERO_SKIP_EN: zero-valued beats are consumed without writing.
module sparse_vector_loader #(
    parameter int LANES  = 16,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IDX_W-1:0]        in_index,
    input  logic [DATA_W-1:0]       in_value,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_vector,
    output logic [IDX_W:0]          out_nnz,
    output logic                    err_dup
);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t state;
    state_t state_nx;

    logic [LANES*DATA_W-1:0] asm_vec;
    logic [LANES*DATA_W-1:0] nxt_vec;
    logic [LANES-1:0]        asm_mask;
    logic [LANES-1:0]        nxt_mask;
    logic [IDX_W:0]          asm_nnz;
    logic [IDX_W:0]          nxt_nnz;
    logic                    slot_full;
    logic                    accept;
    logic                    do_write;
    logic                    hit;
    logic                    slot_free;
    logic                    xfer;

    assign in_ready  = (state == FILL) && !rst;
    assign out_valid = slot_full;
    assign accept    = in_valid && in_ready;
    assign slot_free = !slot_full || out_ready;

`ifdef LOADER_ZERO_SKIP_EN
    assign do_write = accept && (in_value != '0);
`else
    assign do_write = accept;
`endif

    assign hit = do_write && asm_mask[in_index];

    // Assembly buffer contents including the beat accepted this cycle
    always_comb begin
        nxt_vec  = asm_vec;
        nxt_mask = asm_mask;
        nxt_nnz  = asm_nnz;
        if (do_write) begin
            nxt_vec[in_index*DATA_W +: DATA_W] = in_value;
            nxt_mask[in_index] = 1'b1;
            if (!hit) begin
                nxt_nnz = asm_nnz + (IDX_W+1)'(1);
            end
        end
    end

    // Next state and transfer decision into the output slot
    always_comb begin
        state_nx = state;
        xfer     = 1'b0;
        unique case (state)
            FILL: begin
                if (accept && in_last) begin
                    if (slot_free) begin
                        xfer = 1'b1;
                    end else begin
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    xfer     = 1'b1;
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    // Assembly buffer: cleared on reset and whenever a vector moves out
    always_ff @(posedge clk) begin
        if (rst || xfer) begin
            asm_vec  <= '0;
            asm_mask <= '0;
            asm_nnz  <= '0;
        end else begin
            asm_vec  <= nxt_vec;
            asm_mask <= nxt_mask;
            asm_nnz  <= nxt_nnz;
        end
    end

    // Output slot: loads on transfer, empties on downstream handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full  <= 1'b0;
            out_vector <= '0;
            out_nnz    <= '0;
        end else if (xfer) begin
            slot_full  <= 1'b1;
            out_vector <= nxt_vec;
            out_nnz    <= nxt_nnz;
        end else if (out_ready) begin
            slot_full  <= 1'b0;
        end
    end

    // Duplicate-lane flag, one cycle after the offending beat
    always_ff @(posedge clk) begin
        if (rst) begin
            err_dup <= 1'b0;
        end else begin
            err_dup <= hit;
        end
    end

endmodule

// File: tb/tb_sparse_vector_loader.sv
// Scoreboard bench for sparse_vector_loader.
// Expected vectors are built by a bench-side lane model and queued per packet.
module tb_sparse_vector_loader;

    localparam int LANES  = 16;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 4;
    localparam int VW     = LANES * DATA_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_index;
    logic [DATA_W-1:0] in_value;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [VW-1:0]    out_vector;
    logic [IDX_W:0]   out_nnz;
    logic             err_dup;

    sparse_vector_loader #(
        .LANES (LANES),
        .DATA_W(DATA_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_value  (in_value),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vector(out_vector),
        .out_nnz   (out_nnz),
        .err_dup   (err_dup)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int npop  = 0;
    int stalls = 0;

    typedef struct {
        logic [VW-1:0] vec;
        int            nnz;
    } exp_t;

    exp_t q[$];

    logic [VW-1:0]    m_vec;
    logic [LANES-1:0] m_mask;
    int               m_nnz;

    task automatic check(input string tag, input logic [VW-1:0] got,
                         input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_vec  = '0;
        m_mask = '0;
        m_nnz  = 0;
    endtask

    // Output monitor: compare each handshaked vector with the queue head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("vector", out_vector, e.vec);
                check("nnz", VW'(out_nnz), VW'(e.nnz));
                npop++;
            end
        end
    end

    // Drive one beat, wait (bounded) for acceptance, update the model
    task automatic beat(input int idx, input int val, input bit last);
        bit ok;
        bit dup;
        bit wr;
        ok = 0;
        in_valid = 1'b1;
        in_index = IDX_W'(idx);
        in_value = DATA_W'(val);
        in_last  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            stalls++;
        end
        if (!ok) begin
            check("ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
`ifdef LOADER_ZERO_SKIP_EN
        wr = (val != 0);
`else
        wr = 1'b1;
`endif
        dup = wr && m_mask[idx];
        if (wr) begin
            m_vec[idx*DATA_W +: DATA_W] = DATA_W'(val);
            if (!m_mask[idx]) m_nnz++;
            m_mask[idx] = 1'b1;
        end
        check("err_dup", VW'(err_dup), VW'(dup));
        if (last) begin
            exp_t e;
            e.vec = m_vec;
            e.nnz = m_nnz;
            q.push_back(e);
            model_clear();
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", VW'(q.size()), 0);
    endtask

    initial begin
        int p0;
        int s0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_index = '0;
        in_value = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        model_clear();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", VW'(in_ready), 0);
        check("rst_out_valid", VW'(out_valid), 0);
        check("rst_out_vector", out_vector, 0);
        check("rst_out_nnz", VW'(out_nnz), 0);
        check("rst_err_dup", VW'(err_dup), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", VW'(in_ready), 1);
        @(posedge clk);
        #1;

        // Basic three-lane packet
        out_ready = 1'b1;
        beat(3, 8'h11, 0);
        beat(7, 8'h22, 0);
        beat(15, 8'hFF, 1);
        @(negedge clk);
        check("latency_valid", VW'(out_valid), 1);
        idle(2);

        // Duplicate lane on the last beat
        beat(5, 8'h0A, 0);
        beat(5, 8'h0B, 1);
        idle(1);
        check("dup_one_cycle", VW'(err_dup), 0);
        idle(1);

        // Backpressure: P1 parked in slot, P2 held in assembly
        out_ready = 1'b0;
        beat(1, 8'h01, 1);
        beat(2, 8'h02, 0);
        beat(6, 8'h66, 1);
        @(negedge clk);
        check("hold_in_ready", VW'(in_ready), 0);
        check("hold_valid", VW'(out_valid), 1);
        idle(3);
        check("hold_stable_nnz", VW'(out_nnz), 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("p1_valid", VW'(out_valid), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("p2_no_gap", VW'(out_valid), 1);
        check("p2_in_ready", VW'(in_ready), 1);
        idle(2);

        // Single-beat packets back to back
        p0 = npop;
        s0 = stalls;
        for (int i = 0; i < 16; i++) begin
            beat(i, i + 1, 1);
        end
        idle(3);
        check("stream_pops", VW'(npop - p0), 16);
        check("stream_stalls", VW'(stalls - s0), 0);

        // Reset mid-packet with a full slot
        out_ready = 1'b0;
        beat(8, 8'h55, 1);
        beat(1, 8'hA1, 0);
        beat(2, 8'hA2, 0);
        rst = 1'b1;
        q.delete();
        model_clear();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid_valid", VW'(out_valid), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        beat(9, 8'h33, 1);
        idle(2);

        // Zero-valued beat handling
        beat(2, 8'h00, 0);
        beat(4, 8'h44, 1);
        idle(2);

        drain();
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
